// File: rtl/spike_pkg.sv
// Shared spike-network definitions: link widths, packet field offsets and helpers
// common to the router, the neuron grid and the off-grid injector.
package spike_pkg;

  localparam int PACKET_WIDTH = 30;
  localparam int NS_WIDTH     = 21;

  localparam int DX_MSB   = 29;
  localparam int DX_LSB   = 21;
  localparam int DY_MSB   = 20;
  localparam int DY_LSB   = 12;
  localparam int TICK_MSB = 11;
  localparam int TICK_LSB = 8;
  localparam int AXON_MSB = 7;
  localparam int AXON_LSB = 0;

  typedef struct packed {
    logic signed [DX_MSB-DX_LSB:0]     dx;
    logic signed [DY_MSB-DY_LSB:0]     dy;
    logic        [TICK_MSB-TICK_LSB:0] delivery_tick;
    logic        [AXON_MSB-AXON_LSB:0] axon;
  } spike_packet_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [PACKET_WIDTH-1:0] make_packet(
    input logic signed [DX_MSB-DX_LSB:0]     dx,
    input logic signed [DY_MSB-DY_LSB:0]     dy,
    input logic        [TICK_MSB-TICK_LSB:0] delivery_tick,
    input logic        [AXON_MSB-AXON_LSB:0] axon
  );
    spike_packet_t p;
    p.dx            = dx;
    p.dy            = dy;
    p.delivery_tick = delivery_tick;
    p.axon          = axon;
    return p;
  endfunction

endpackage

// File: rtl/spike_injector_tx_fifo.sv
// Tick-committed FIFO: host writes land in a pending region that only becomes
// readable once a tick moves the commit pointer past them.
module spike_commit_fifo
  import spike_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = PACKET_WIDTH,
  localparam int PW   = ptr_width(DEPTH),
  localparam int AW   = PW - 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  input  logic             ren,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout,
  output logic [PW-1:0]    committed_count,
  output logic [PW-1:0]    pending_count,
  output logic             write_dropped,
  output logic             read_rejected
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    commit_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_write;
  logic             do_pop;

  assign full  = (PW'(wr_ptr - rd_ptr) == PW'(DEPTH));
  assign empty = (rd_ptr == commit_ptr);

  assign do_write      = wen && !full;
  assign do_pop        = ren && !empty;
  assign write_dropped = wen && full;
  assign read_rejected = ren && empty;

  assign committed_count = PW'(commit_ptr - rd_ptr);
  assign pending_count   = PW'(wr_ptr - commit_ptr);

  assign dout = mem[rd_ptr[AW-1:0]];

  // Commit takes the pre-write pointer, so a write alongside tick joins the next batch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      if (tick)     commit_ptr <= wr_ptr;
      if (do_pop)   rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spike_injector_tx.sv
// Off-grid spike source driving a router west port; adds sticky protocol
// error flags around the tick-committed buffer.
module spike_injector_tx
  import spike_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PACKET_WIDTH = spike_pkg::PACKET_WIDTH,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    host_wen,
  input  logic [PACKET_WIDTH-1:0] host_packet,
  output logic                    host_full,
  input  logic                    ren_in,
  output logic                    empty_out,
  output logic [PACKET_WIDTH-1:0] dout,
  output logic [PW-1:0]           committed_count,
  output logic [PW-1:0]           pending_count,
  output logic                    overflow_error,
  output logic                    underflow_error
);

  logic write_dropped;
  logic read_rejected;

  spike_commit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PACKET_WIDTH)
  ) u_fifo (
    .clk             (clk),
    .reset_n         (reset_n),
    .tick            (tick),
    .wen             (host_wen),
    .din             (host_packet),
    .ren             (ren_in),
    .full            (host_full),
    .empty           (empty_out),
    .dout            (dout),
    .committed_count (committed_count),
    .pending_count   (pending_count),
    .write_dropped   (write_dropped),
    .read_rejected   (read_rejected)
  );

  // Errors are sticky until reset so the host can poll them at leisure.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else begin
      if (write_dropped) overflow_error <= 1'b1;
      if (read_rejected) underflow_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spike_injector_tx.sv
// Directed bench for spike_injector_tx: commit batching, pops, full/empty
// boundaries, wrap-around streaming and mid-stream reset.
module tb_spike_injector_tx;
  import spike_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic        host_wen;
  logic [29:0] host_packet;
  logic        host_full;
  logic        ren_in;
  logic        empty_out;
  logic [29:0] dout;
  logic [4:0]  committed_count;
  logic [4:0]  pending_count;
  logic        overflow_error;
  logic        underflow_error;

  int n_assert = 0;
  int n_fail   = 0;

  spike_injector_tx #(.DEPTH(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .tick            (tick),
    .host_wen        (host_wen),
    .host_packet     (host_packet),
    .host_full       (host_full),
    .ren_in          (ren_in),
    .empty_out       (empty_out),
    .dout            (dout),
    .committed_count (committed_count),
    .pending_count   (pending_count),
    .overflow_error  (overflow_error),
    .underflow_error (underflow_error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_pkt(input logic [29:0] p);
    host_wen    = 1'b1;
    host_packet = p;
    step();
    host_wen    = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  logic [29:0] ovf_pkts [16];
  logic [29:0] wrap_pkts [40];
  logic [29:0] p3;
  logic [29:0] fresh;
  int rd_idx;
  int max_total;

  initial begin
    reset_n = 1'b0; tick = 1'b0; host_wen = 1'b0; host_packet = '0; ren_in = 1'b0;
    step(); step();
    reset_n = 1'b1;
    check("rst_empty", 32'(empty_out), 32'd1);
    check("rst_full", 32'(host_full), 32'd0);
    check("rst_ccount", 32'(committed_count), 32'd0);
    check("rst_pcount", 32'(pending_count), 32'd0);
    check("rst_ovf", 32'(overflow_error), 32'd0);
    check("rst_udf", 32'(underflow_error), 32'd0);

    // Three writes, no tick: nothing visible yet
    write_pkt(30'h0000_0A01);
    write_pkt(30'h0000_0B02);
    write_pkt(30'h0000_0C03);
    check("pre_tick_empty", 32'(empty_out), 32'd1);
    check("pre_tick_pcount", 32'(pending_count), 32'd3);
    check("pre_tick_ccount", 32'(committed_count), 32'd0);
    pulse_tick();
    check("post_tick_empty", 32'(empty_out), 32'd0);
    check("post_tick_dout", 32'(dout), 32'h0000_0A01);
    check("post_tick_ccount", 32'(committed_count), 32'd3);
    check("post_tick_pcount", 32'(pending_count), 32'd0);

    // Back-to-back pops
    ren_in = 1'b1;
    check("pop0_dout", 32'(dout), 32'h0000_0A01);
    step();
    check("pop1_dout", 32'(dout), 32'h0000_0B02);
    step();
    check("pop2_dout", 32'(dout), 32'h0000_0C03);
    step();
    ren_in = 1'b0;
    check("drain_empty", 32'(empty_out), 32'd1);
    check("drain_udf", 32'(underflow_error), 32'd0);
    ren_in = 1'b1;
    step();
    ren_in = 1'b0;
    check("udf_set", 32'(underflow_error), 32'd1);
    check("udf_ccount", 32'(committed_count), 32'd0);
    check("udf_empty", 32'(empty_out), 32'd1);
    step();
    check("udf_sticky", 32'(underflow_error), 32'd1);

    // Fill to DEPTH, then one dropped write
    for (int i = 0; i < 16; i++) ovf_pkts[i] = 30'(32'h0123_4500 + 32'(i) * 32'h0001_0011);
    for (int i = 0; i < 15; i++) write_pkt(ovf_pkts[i]);
    check("full_at_15", 32'(host_full), 32'd0);
    write_pkt(ovf_pkts[15]);
    check("full_at_16", 32'(host_full), 32'd1);
    check("full_pcount", 32'(pending_count), 32'd16);
    check("full_no_ovf", 32'(overflow_error), 32'd0);
    write_pkt(30'h3FFF_FFFF);
    check("ovf_set", 32'(overflow_error), 32'd1);
    check("ovf_pcount", 32'(pending_count), 32'd16);
    pulse_tick();
    check("full_ccount", 32'(committed_count), 32'd16);
    check("full_after_tick", 32'(host_full), 32'd1);
    ren_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("full_pop%0d", i), 32'(dout), 32'(ovf_pkts[i]));
      step();
    end
    ren_in = 1'b0;
    check("full_drain_empty", 32'(empty_out), 32'd1);
    check("full_drain_notfull", 32'(host_full), 32'd0);

    // Write coinciding with tick belongs to the next batch
    p3 = make_packet(-9'sd3, 9'sd5, 4'd7, 8'hA5);
    write_pkt(30'h0000_1111);
    write_pkt(30'h0000_2222);
    host_wen = 1'b1; host_packet = p3; tick = 1'b1;
    step();
    host_wen = 1'b0; tick = 1'b0;
    check("tw_ccount", 32'(committed_count), 32'd2);
    check("tw_pcount", 32'(pending_count), 32'd1);
    ren_in = 1'b1;
    check("tw_dout0", 32'(dout), 32'h0000_1111);
    step();
    check("tw_dout1", 32'(dout), 32'h0000_2222);
    step();
    ren_in = 1'b0;
    check("tw_hidden", 32'(empty_out), 32'd1);
    pulse_tick();
    check("tw_visible", 32'(empty_out), 32'd0);
    check("tw_dout2", 32'(dout), 32'(p3));
    check("tw_p3_field", 32'(dout[AXON_MSB:AXON_LSB]), 32'h0000_00A5);
    ren_in = 1'b1;
    step();
    ren_in = 1'b0;
    check("tw_drained", 32'(empty_out), 32'd1);

    // Wrap-around streaming: batches of 5 with concurrent pops
    rd_idx = 0;
    max_total = 0;
    for (int i = 0; i < 40; i++) begin
      wrap_pkts[i] = 30'(32'h0ABC_0000 + 32'(i) * 32'h0000_0107);
      host_wen = 1'b1;
      host_packet = wrap_pkts[i];
      tick = ((i % 5) == 4);
      ren_in = !empty_out;
      if (ren_in && rd_idx < 40) begin
        check($sformatf("wrap_dout%0d", rd_idx), 32'(dout), 32'(wrap_pkts[rd_idx]));
        rd_idx++;
      end
      step();
      if (int'(committed_count) + int'(pending_count) > max_total)
        max_total = int'(committed_count) + int'(pending_count);
    end
    host_wen = 1'b0;
    tick = 1'b1;
    ren_in = 1'b0;
    step();
    tick = 1'b0;
    for (int c = 0; c < 50 && rd_idx < 40; c++) begin
      ren_in = !empty_out;
      if (ren_in) begin
        check($sformatf("wrap_dout%0d", rd_idx), 32'(dout), 32'(wrap_pkts[rd_idx]));
        rd_idx++;
      end
      step();
    end
    ren_in = 1'b0;
    check("wrap_all_popped", 32'(rd_idx), 32'd40);
    check("wrap_max_le_depth", 32'(max_total <= 16), 32'd1);
    check("wrap_end_empty", 32'(empty_out), 32'd1);

    // Mid-stream reset: 4 committed, 2 pending
    for (int i = 0; i < 4; i++) write_pkt(30'(32'h0055_0000 + 32'(i)));
    pulse_tick();
    write_pkt(30'h0066_0000);
    write_pkt(30'h0066_0001);
    check("mid_ccount", 32'(committed_count), 32'd4);
    check("mid_pcount", 32'(pending_count), 32'd2);
    reset_n = 1'b0;
    step();
    check("mr_empty", 32'(empty_out), 32'd1);
    check("mr_ccount", 32'(committed_count), 32'd0);
    check("mr_pcount", 32'(pending_count), 32'd0);
    check("mr_ovf", 32'(overflow_error), 32'd0);
    check("mr_udf", 32'(underflow_error), 32'd0);
    check("mr_full", 32'(host_full), 32'd0);
    reset_n = 1'b1;
    fresh = 30'h2AAA_AAAA;
    write_pkt(fresh);
    pulse_tick();
    check("mr_new_empty", 32'(empty_out), 32'd0);
    check("mr_new_dout", 32'(dout), 32'(fresh));
    check("mr_new_ccount", 32'(committed_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
